// File: rtl/rs_encode_feeder.sv
// rtl/rs_encode_feeder.sv - cuts a byte stream into K-byte RS codeword payloads
//
// Purpose:
//   Upstream stage of the Reed-Solomon encoder wrapper. Accepts an
//   arbitrary-length byte message on a val/rdy stream and cuts it into
//   K_BYTES-byte payloads. Each payload gets one start pulse and exactly
//   K_BYTES data-enabled bytes. The final short payload is zero-padded.
//   A new codeword is never started while the encoder reports busy.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   src_feeder_data_val/_data    source byte stream (valid + byte)
//   src_feeder_data_last         last byte of a message, qualified by val
//   feeder_src_data_rdy          byte accepted this cycle when val is high
//   feeder_encoder_start_encode  one-cycle start pulse to the encoder
//   feeder_encoder_data_enable   encoder byte valid
//   feeder_encoder_data          encoder byte
//   encoder_feeder_encoding      encoder busy, from start until parity is out
//   feeder_codeword_done         one-cycle pulse when the encoder goes idle
//   feeder_padding               high while zero-pad bytes are presented

module rs_encode_feeder #(
    parameter int K_BYTES = 239,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       src_feeder_data_val,
    input  logic [7:0] src_feeder_data,
    input  logic       src_feeder_data_last,
    output logic       feeder_src_data_rdy,
    output logic       feeder_encoder_start_encode,
    output logic       feeder_encoder_data_enable,
    output logic [7:0] feeder_encoder_data,
    input  logic       encoder_feeder_encoding,
    output logic       feeder_codeword_done,
    output logic       feeder_padding
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAD   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(K_BYTES - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_drain_first;
    logic             w_drain_first_nxt;

    logic             r_rdy;
    logic             r_start;
    logic             r_de;
    logic [7:0]       r_data;
    logic             r_done;
    logic             r_pad;

    logic             w_rdy_nxt;
    logic             w_start_nxt;
    logic             w_de_nxt;
    logic [7:0]       w_data_nxt;
    logic             w_done_nxt;
    logic             w_pad_nxt;
    logic             w_accept;

    // r_rdy is high exactly in DATA, so this is the source handshake.
    assign w_accept = r_rdy & src_feeder_data_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_drain_first <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_drain_first <= w_drain_first_nxt;
        end
    end

    // r_cnt counts bytes already scheduled for the encoder in this codeword.
    // The counter may reach K_BYTES on the final byte; it is cleared in START.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_drain_first_nxt = 1'b0;
        w_de_nxt          = 1'b0;
        w_data_nxt        = 8'h00;
        w_done_nxt        = 1'b0;
        w_pad_nxt         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (src_feeder_data_val && !encoder_feeder_encoding) begin
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_DATA;
            end

            S_DATA: begin
                if (w_accept) begin
                    w_de_nxt   = 1'b1;
                    w_data_nxt = src_feeder_data;
                    w_cnt_nxt  = r_cnt + C_ONE;
                    // The K-th byte closes the codeword even without last;
                    // any remaining message bytes go to the next codeword.
                    if (r_cnt == C_LAST) begin
                        w_state_nxt       = S_DRAIN;
                        w_drain_first_nxt = 1'b1;
                    end else if (src_feeder_data_last) begin
                        w_state_nxt = S_PAD;
                    end
                end
            end

            S_PAD: begin
                w_de_nxt   = 1'b1;
                w_data_nxt = 8'h00;
                w_pad_nxt  = 1'b1;
                w_cnt_nxt  = r_cnt + C_ONE;
                if (r_cnt == C_LAST) begin
                    w_state_nxt       = S_DRAIN;
                    w_drain_first_nxt = 1'b1;
                end
            end

            S_DRAIN: begin
                // The encoder may not have raised busy yet when the last
                // byte goes out, so the first DRAIN cycle ignores it.
                if (!r_drain_first && !encoder_feeder_encoding) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_start_nxt = (w_state_nxt == S_START);
        w_rdy_nxt   = (w_state_nxt == S_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy   <= 1'b0;
            r_start <= 1'b0;
            r_de    <= 1'b0;
            r_data  <= 8'h00;
            r_done  <= 1'b0;
            r_pad   <= 1'b0;
        end else begin
            r_rdy   <= w_rdy_nxt;
            r_start <= w_start_nxt;
            r_de    <= w_de_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_pad   <= w_pad_nxt;
        end
    end

    assign feeder_src_data_rdy         = r_rdy;
    assign feeder_encoder_start_encode = r_start;
    assign feeder_encoder_data_enable  = r_de;
    assign feeder_encoder_data         = r_data;
    assign feeder_codeword_done        = r_done;
    assign feeder_padding              = r_pad;

endmodule

// File: doc/rs_encode_feeder.md
Name: rs_encode_feeder

Overview:
- Upstream stage of the Reed-Solomon encoder wrapper.
- Accepts an arbitrary-length byte message on a val/rdy stream and cuts it into K-byte codeword payloads.
- For each payload it issues the encoder start pulse and presents exactly K data-enabled bytes, zero-padding the final short payload.
- It never starts a new codeword while the encoder reports encoding in progress.

Parameters:
- K_BYTES, 239, data bytes per codeword (RS(255,239)); legal range 2..255.
- CNT_W, 8, width of the payload byte counter; must satisfy 2^CNT_W > K_BYTES.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- src_feeder_data_val  in  1  source byte valid.
- src_feeder_data  in  8  source byte.
- src_feeder_data_last  in  1  marks the final byte of a message; qualified by val.
- feeder_src_data_rdy  out  1  feeder accepts the byte this cycle.
- feeder_encoder_start_encode  out  1  one-cycle start pulse to the encoder.
- feeder_encoder_data_enable  out  1  encoder data byte valid.
- feeder_encoder_data  out  8  encoder data byte.
- encoder_feeder_encoding  in  1  encoder busy: high from start until parity output completes.
- feeder_codeword_done  out  1  one-cycle pulse when the encoder goes idle after a codeword.
- feeder_padding  out  1  high while zero-pad bytes are being emitted.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE and the byte counter to 0.
  - All outputs are 0: rdy, start_encode, data_enable, data, codeword_done, padding.
  - Reset mid-codeword abandons the codeword silently; no pad bytes are emitted.
- All encoder-side outputs are registered. Accepted source bytes appear on feeder_encoder_data one cycle after the val&rdy handshake.
- States:
  - IDLE → START when src_feeder_data_val=1 and encoder_feeder_encoding=0.
  - START: lasts one cycle with start_encode=1, data_enable=0, rdy=0. Clears the counter. Always → DATA.
  - DATA: rdy=1. On val&rdy, the byte is forwarded with data_enable=1 next cycle and the counter increments. Transitions on the accepted byte:
    - If counter==K_BYTES-1 (K-th byte) → DRAIN. This applies regardless of last; with last=0 the remaining message bytes go to the next codeword.
    - Else if last=1 → PAD.
    - Otherwise stay in DATA. With val=0, data_enable=0 next cycle; the encoder tolerates data_enable gaps.
  - PAD:
    - rdy=0 and padding=1.
    - Emits data=0x00 with data_enable=1 every cycle until K_BYTES total bytes have been presented, then → DRAIN.
    - The number of pad bytes is K_BYTES minus the number of message bytes in the codeword.
  - DRAIN: rdy=0. The first DRAIN cycle ignores encoding, to cover encoder response latency. Afterwards:
    - When encoding=0: codeword_done pulses for one cycle and the state → IDLE.
    - While encoding=1: wait.
- rdy is a registered function of state and is asserted only in DATA. The counter never exceeds K_BYTES-1 in DATA, so rdy drops in the cycle after the K-th byte is accepted.
- Payload boundaries:
  - Exactly one start pulse per codeword.
  - Exactly K_BYTES data_enable cycles between consecutive start pulses.
  - No data_enable outside DATA/PAD output cycles.
- A message whose length is an exact multiple of K_BYTES produces no padding. last on the K-th byte ends the message with no extra codeword.
- A single-byte message (last=1 on the first byte) produces 1 data byte plus K_BYTES-1 zero bytes.
- Back-to-back messages: the next START cannot occur before DRAIN completes. Minimum gap from one codeword_done to the next start pulse is 1 cycle (IDLE→START).
- If encoding=1 while in IDLE (encoder still busy from an external cause), the feeder waits and src rdy stays 0.

Test Plan:
- K_BYTES=4, message 0x11,0x22,0x33,0x44 with last on 0x44:
  - Required: one start pulse, then data_enable on 11,22,33,44, no padding.
  - codeword_done fires after encoding falls.
- K_BYTES=4, message 0xA0,0xA1 with last on 0xA1:
  - Required: enabled bytes A0,A1,00,00.
  - padding high for exactly 2 cycles; rdy low during PAD.
- K_BYTES=4, 6-byte message 01..06 with last on 06:
  - Required: codeword 1 carries 01..04; codeword 2 carries 05,06,00,00.
  - Two start pulses; second start only after codeword_done.
- Source val toggled 1/0 every cycle, K_BYTES=4:
  - Required: bytes forwarded in order with matching data_enable gaps.
  - Exactly 4 enables per codeword; no duplication or loss.
- encoding held high 20 cycles after the last byte:
  - Required: state stays DRAIN and rdy stays 0.
  - codeword_done fires exactly 1 cycle after encoding falls.
  - A pending source val starts the next codeword no earlier than the following cycle.
- rst asserted during PAD:
  - Required: all outputs 0 immediately (asynchronously), no further enables.
  - After deassertion, a new message starts cleanly with counter 0.
